// File: rtl/uart_doc_loader_if.sv
// Document write-port interface between the UART loader and the document RAM arbiter.
//   doc_we    : write request, held until doc_ready is seen
//   doc_a     : write address {row[3:0], col[4:0]}
//   doc_d     : write data (ASCII)
//   doc_ready : arbiter grant; a write is accepted on a cycle with doc_we && doc_ready
// master = the loader (request side), slave = the arbiter / RAM side.
interface uart_doc_loader_if;
  logic       doc_we;
  logic [8:0] doc_a;
  logic [7:0] doc_d;
  logic       doc_ready;

  modport master (output doc_we, output doc_a, output doc_d, input doc_ready);
  modport slave  (input doc_we, input doc_a, input doc_d, output doc_ready);
endinterface

// File: rtl/uart_doc_loader.sv
// UART 8N1 receiver that types host-terminal text into the document RAM.
// Printable ASCII is written at the cursor {row, col}; LF starts a new row;
// other bytes are ignored. Writes use a request/grant handshake on doc.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rx_i          : asynchronous UART line (idle high)
//   enable_i      : when 0 received bytes are discarded
//   clear_i       : one-cycle pulse, cursor to (0,0) and sticky flags cleared
//   doc           : write port (doc_we/doc_a/doc_d out, doc_ready in)
//   byte_count_o  : characters written since reset/clear, saturating at 511
//   frame_err_o   : sticky, a stop bit was sampled low
//   overrun_o     : sticky, a printable byte arrived while a write was pending
//   full_o        : cursor has moved past the last row
//   busy_o        : receive FSM is not idle
module uart_doc_loader #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int COLS         = 20,
  parameter int ROWS         = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  uart_doc_loader_if.master          doc,
  output logic [8:0]                 byte_count_o,
  output logic                       frame_err_o,
  output logic                       overrun_o,
  output logic                       full_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    ROW_END  = 4'(ROWS);
  localparam logic [4:0]    COL_LAST = 5'(COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  state_t        state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  logic [3:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic          we_q;
  logic [8:0]    a_q;
  logic [7:0]    d_q;
  logic [8:0]    count_q;
  logic          ferr_q, ovr_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receive FSM. clear_i intentionally does not touch it: a frame in flight completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_BIT;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!rx_sync_q) begin
            state_q <= S_DATA;
            cnt_q   <= FULL_BIT;
            bit_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= FULL_BIT;
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        S_STOP: begin
          if (cnt_q != '0)    cnt_q   <= cnt_q - CW'(1);
          else if (rx_sync_q) state_q <= S_IDLE;
          else                state_q <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (rx_sync_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stop-bit sample cycle: either a good byte or a framing error.
  logic stop_sample, deliver, frame_bad;
  logic is_lf, is_print, full, accept, start_wr, overrun_hit;

  assign stop_sample = (state_q == S_STOP) && (cnt_q == '0);
  assign deliver     = stop_sample && rx_sync_q;
  assign frame_bad   = stop_sample && !rx_sync_q;
  assign is_lf       = (shift_q == 8'h0A);
  assign is_print    = (shift_q >= 8'h20) && (shift_q <= 8'h7E);
  assign full        = (row_q == ROW_END);
  assign accept      = we_q && doc.doc_ready;
  assign start_wr    = deliver && enable_i && is_print && !full && !we_q;
  assign overrun_hit = deliver && enable_i && is_print && !full && we_q;

  // Cursor next state. An accepted write advances first; an LF in the same
  // cycle then starts a new row from the advanced position. Row never passes ROWS.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_d != ROW_END) row_d = row_d + 4'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
    if (deliver && enable_i && is_lf) begin
      col_d = '0;
      if (row_d != ROW_END) row_d = row_d + 4'd1;
    end
  end

  // Write request, cursor and status. clear_i has priority over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (accept) begin
        we_q <= 1'b0;
        if (count_q != 9'd511) count_q <= count_q + 9'd1;
      end
      if (start_wr) begin
        we_q <= 1'b1;
        a_q  <= {row_q, col_q};
        d_q  <= shift_q;
      end
      if (frame_bad)   ferr_q <= 1'b1;
      if (overrun_hit) ovr_q  <= 1'b1;
    end
  end

  assign doc.doc_we   = we_q;
  assign doc.doc_a    = a_q;
  assign doc.doc_d    = d_q;
  assign byte_count_o = count_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign full_o       = full;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_doc_loader.sv
// Directed bench for uart_doc_loader with a fast bit time (16 clocks per bit).
module tb_uart_doc_loader;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [8:0] byte_count;
  logic       frame_err, overrun, full, busy;

  uart_doc_loader_if dif ();

  uart_doc_loader #(.CLKS_PER_BIT(CPB), .COLS(20), .ROWS(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .enable_i     (enable),
    .clear_i      (clear),
    .doc          (dif.master),
    .byte_count_o (byte_count),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .full_o       (full),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Accepted-write log and doc_we rising-edge bookkeeping, sampled on the falling edge.
  logic [8:0] wr_a[$];
  logic [7:0] wr_d[$];
  int rise_cnt = 0;
  int rise_ok = 0;
  logic we_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.doc_we && dif.doc_ready) begin
        wr_a.push_back(dif.doc_a);
        wr_d.push_back(dif.doc_d);
        $display("write a=0x%03h d=0x%02h", dif.doc_a, dif.doc_d);
      end
      if (dif.doc_we && !we_prev) begin
        rise_cnt++;
        if (!busy && busy_prev) rise_ok++;
      end
    end
    we_prev = dif.doc_we;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    $display("sent byte 0x%02h stop=%0b", b, stop_bit);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.doc_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    compared++; if (dif.doc_we !== 1'b0) begin mismatched++; $display("FAIL reset_we got=%b exp=0", dif.doc_we); end
    compared++; if (dif.doc_a !== 9'h000) begin mismatched++; $display("FAIL reset_a got=%h exp=000", dif.doc_a); end
    compared++; if (dif.doc_d !== 8'h00) begin mismatched++; $display("FAIL reset_d got=%h exp=00", dif.doc_d); end
    compared++; if (byte_count !== 9'd0) begin mismatched++; $display("FAIL reset_count got=%0d exp=0", byte_count); end
    compared++; if ({frame_err, overrun, full, busy} !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got=%b exp=0000", {frame_err, overrun, full, busy}); end
  endtask

  task automatic test_single();
    int r0, k0;
    r0 = rise_cnt;
    k0 = rise_ok;
    send_byte(8'h41, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 1) begin mismatched++; $display("FAIL single_nwrites got=%0d exp=1", wr_a.size()); end
    else begin
      compared++; if (wr_a[0] !== 9'h000) begin mismatched++; $display("FAIL single_a got=%h exp=000", wr_a[0]); end
      compared++; if (wr_d[0] !== 8'h41) begin mismatched++; $display("FAIL single_d got=%h exp=41", wr_d[0]); end
    end
    compared++; if (rise_cnt - r0 !== 1) begin mismatched++; $display("FAIL single_pulses got=%0d exp=1", rise_cnt - r0); end
    compared++; if (rise_ok - k0 !== 1) begin mismatched++; $display("FAIL single_timing got=%0d exp=1", rise_ok - k0); end
    compared++; if (byte_count !== 9'd1) begin mismatched++; $display("FAIL single_count got=%0d exp=1", byte_count); end
    compared++; if (dif.doc_we !== 1'b0) begin mismatched++; $display("FAIL single_we_drop got=%b exp=0", dif.doc_we); end
  endtask

  task automatic test_filter();
    clear_pulse();
    enable = 1'b0;
    send_byte(8'h41, 1'b1);
    enable = 1'b1;
    send_byte(8'h0D, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h42, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 1) begin mismatched++; $display("FAIL filter_nwrites got=%0d exp=1", wr_a.size()); end
    else begin
      compared++; if ({wr_a[0], wr_d[0]} !== {9'h000, 8'h42}) begin mismatched++; $display("FAIL filter_write got=%h/%h exp=000/42", wr_a[0], wr_d[0]); end
    end
    compared++; if (byte_count !== 9'd1) begin mismatched++; $display("FAIL filter_count got=%0d exp=1", byte_count); end
  endtask

  task automatic test_lf();
    logic [8:0] exp_a[3];
    logic [7:0] exp_d[3];
    exp_a = '{9'h000, 9'h001, 9'h020};
    exp_d = '{8'h41, 8'h42, 8'h43};
    clear_pulse();
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h43, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 3) begin mismatched++; $display("FAIL lf_nwrites got=%0d exp=3", wr_a.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if ({wr_a[i], wr_d[i]} !== {exp_a[i], exp_d[i]}) begin
          mismatched++;
          $display("FAIL lf_write%0d got=%h/%h exp=%h/%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    compared++; if (byte_count !== 9'd3) begin mismatched++; $display("FAIL lf_count got=%0d exp=3", byte_count); end
  endtask

  task automatic test_wrap_full();
    clear_pulse();
    for (int i = 0; i < 21; i++) send_byte(8'h78, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 21) begin mismatched++; $display("FAIL wrap_nwrites got=%0d exp=21", wr_a.size()); end
    else begin
      compared++; if (wr_a[19] !== 9'h013) begin mismatched++; $display("FAIL wrap_a20 got=%h exp=013", wr_a[19]); end
      compared++; if (wr_a[20] !== 9'h020) begin mismatched++; $display("FAIL wrap_a21 got=%h exp=020", wr_a[20]); end
    end
    compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL wrap_notfull got=%b exp=0", full); end
    for (int i = 0; i < 14; i++) send_byte(8'h0A, 1'b1);
    tick(2);
    compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL full_set got=%b exp=1", full); end
    send_byte(8'h79, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 21) begin mismatched++; $display("FAIL full_nowrite got=%0d exp=21", wr_a.size()); end
    compared++; if (byte_count !== 9'd21) begin mismatched++; $display("FAIL full_count got=%0d exp=21", byte_count); end
  endtask

  task automatic test_backpressure();
    int unstable;
    clear_pulse();
    dif.doc_ready = 1'b0;
    send_byte(8'h51, 1'b1);
    compared++; if ({dif.doc_we, dif.doc_a, dif.doc_d} !== {1'b1, 9'h000, 8'h51}) begin
      mismatched++; $display("FAIL bp_req got=%b/%h/%h exp=1/000/51", dif.doc_we, dif.doc_a, dif.doc_d);
    end
    unstable = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if ({dif.doc_we, dif.doc_a, dif.doc_d} !== {1'b1, 9'h000, 8'h51}) unstable++;
    end
    compared++; if (unstable !== 0) begin mismatched++; $display("FAIL bp_stable got=%0d changed cycles exp=0", unstable); end
    send_byte(8'h52, 1'b1);
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    compared++; if (dif.doc_d !== 8'h51) begin mismatched++; $display("FAIL bp_data_kept got=%h exp=51", dif.doc_d); end
    dif.doc_ready = 1'b1;
    tick(4);
    compared++; if (wr_a.size() !== 1) begin mismatched++; $display("FAIL bp_nwrites got=%0d exp=1", wr_a.size()); end
    else begin
      compared++; if ({wr_a[0], wr_d[0]} !== {9'h000, 8'h51}) begin mismatched++; $display("FAIL bp_write got=%h/%h exp=000/51", wr_a[0], wr_d[0]); end
    end
    compared++; if (byte_count !== 9'd1) begin mismatched++; $display("FAIL bp_count got=%0d exp=1", byte_count); end
  endtask

  task automatic test_frame_err();
    wr_a.delete();
    wr_d.delete();
    send_byte(8'h55, 1'b0);
    tick(2);
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ferr_idle got=%b exp=0", busy); end
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL glitch_start got=%b exp=1", busy); end
    tick(20);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    compared++; if (wr_a.size() !== 0) begin mismatched++; $display("FAIL ferr_nowrite got=%0d exp=0", wr_a.size()); end
    compared++; if (byte_count !== 9'd1) begin mismatched++; $display("FAIL ferr_count got=%0d exp=1", byte_count); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), 1'b1);
    tick(2);
    compared++; if (byte_count !== 9'd5) begin mismatched++; $display("FAIL clr_pre_count got=%0d exp=5", byte_count); end
    clear_pulse();
    compared++; if ({byte_count, frame_err, overrun, full} !== {9'd0, 3'b000}) begin
      mismatched++; $display("FAIL clr_state got=%0d/%b%b%b exp=0/000", byte_count, frame_err, overrun, full);
    end
    send_byte(8'h5A, 1'b1);
    tick(4);
    compared++; if (wr_a.size() !== 1) begin mismatched++; $display("FAIL clr_nwrites got=%0d exp=1", wr_a.size()); end
    else begin
      compared++; if ({wr_a[0], wr_d[0]} !== {9'h000, 8'h5A}) begin mismatched++; $display("FAIL clr_write got=%h/%h exp=000/5a", wr_a[0], wr_d[0]); end
    end
    compared++; if (byte_count !== 9'd1) begin mismatched++; $display("FAIL clr_count got=%0d exp=1", byte_count); end
  endtask

  initial begin
    dif.doc_ready = 1'b1;
    test_reset();
    test_single();
    test_filter();
    test_lf();
    test_wrap_full();
    test_backpressure();
    test_frame_err();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_doc_loader.md
Name: uart_doc_loader

Overview:
- UART 8N1 receiver that loads text typed on a host terminal into the document RAM. It is the receive-side counterpart of the messenger transmitter.
- Deserialises bytes from RsRx and maps printable ASCII and line feeds onto document block addresses {row[3:0], col[4:0]}.
- Drives a write request port that the top arbitrates with the text editor and the UART reader.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per bit (100 MHz / 9600 baud); minimum 4.
COLS, 20, visible columns per row; col range 0..COLS-1.
ROWS, 15, visible rows; row range 0..ROWS-1.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
rx  in  1  UART line, asynchronous, idle high
enable  in  1  loading enabled; when 0, received bytes are discarded
clear  in  1  one-cycle pulse: cursor to (0,0), sticky flags cleared
doc_ready  in  1  arbiter grant; a write is accepted on a cycle with doc_we && doc_ready
doc_we  out  1  write request
doc_a  out  9  write address {row, col}
doc_d  out  8  write data (ASCII)
byte_count  out  9  characters written since reset or clear (saturates at 511)
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte received while a write was still pending
full  out  1  cursor past the last cell
busy  out  1  receive FSM not in IDLE

Behaviour:
- Reset and clear: all outputs 0; cursor row=0, col=0; receive FSM in IDLE; pending write dropped. The synchroniser flops reset to 1. clear does not abort a frame in progress.
- rx passes through a 2-FF synchroniser before any use. All timing in these rules refers to the synchronised signal.
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge of rx moves to START and loads the bit counter with CLKS_PER_BIT/2.
  - START: at count 0, rx=0 moves to DATA with the counter reloaded to CLKS_PER_BIT-1. rx=1 is a glitch and returns to IDLE.
  - DATA: samples 8 bits LSB-first, one per CLKS_PER_BIT cycles, into a shift register. After the 8th sample, moves to STOP.
  - STOP: samples at mid-bit. rx=1 delivers the byte and returns to IDLE. rx=0 sets frame_err, discards the byte, and moves to WAIT_HIGH.
  - WAIT_HIGH: returns to IDLE once rx=1.
- Byte delivery happens on the cycle the stop bit is sampled, cycle T. Classification takes effect at T+1:
  - enable=0, or CR (0x0D), or a byte outside 0x20..0x7E other than LF: dropped; no state change.
  - LF (0x0A): col=0, row=row+1; no write.
  - Printable byte with full=0: doc_we=1 from T+1, doc_a={row,col}, doc_d=byte.
  - Printable byte with full=1: dropped.
- Write handshake:
  - doc_we, doc_a and doc_d stay stable until a cycle with doc_ready=1.
  - On that cycle the write is taken and doc_we drops the next cycle. byte_count increments, and col advances.
  - When col reaches COLS-1 and a write is taken, the cursor wraps: col=0, row=row+1.
- Full:
  - full=1 when row==ROWS.
  - An LF or a wrap with row==ROWS-1 sets row=ROWS and full=1. Only clear or rst recovers.
- Overrun: a printable byte delivered while doc_we=1 sets overrun, and the new byte is discarded. The pending write is unaffected.
- Simultaneous clear and write acceptance: clear wins; the cursor ends at (0,0) and byte_count at 0.
- rst mid-frame: the FSM returns to IDLE. The next falling edge starts a fresh frame.

Test Plan:
- CLKS_PER_BIT=16, doc_ready=1, send 0x41 'A' -> exactly one doc_we pulse with doc_a=0x000, doc_d=0x41, at T+1 after the stop sample; byte_count=1.
- Send "AB", LF, "C" -> writes (0,0)=0x41, (0,1)=0x42, (1,0)=0x43; doc_a=0x020 for 'C'; byte_count=3.
- Send 21 'x' characters -> the 20th write goes to doc_a=0x013 and the 21st to 0x020; then send 14 LF -> full=1 and later bytes produce no doc_we.
- Hold doc_ready=0 for 40 cycles after 'Q' -> doc_we, doc_a and doc_d stay constant; a second byte arriving meanwhile sets overrun=1, and only 'Q' is written after doc_ready rises.
- Drive a 0-stop-bit frame, then a 3-cycle low glitch on idle rx -> frame_err=1, no write, and the glitch returns to IDLE with busy=0 and no byte delivered.
- Pulse clear after 5 writes, then send 'Z' -> byte_count=1, doc_a=0x000, frame_err=0, overrun=0.
